// File: rtl/hc595_chain_driver.sv
// Serial driver for a cascade of 74HC595 shift registers: shifts an 8*CHAIN-bit
// word out on ds/sh_cp at a programmable rate, then latches it with st_cp.
module hc595_chain_driver #(
    parameter int CHAIN     = 2,
    parameter int DIV       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [8*CHAIN-1:0]   data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 sh_cp,
    output logic                 st_cp,
    output logic                 ds,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int N  = 8 * CHAIN;
    localparam int BW = $clog2(N + 1);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t          state, state_nx;
    logic [N-1:0]    shreg, hold, shreg_adv;
    logic            have_word;
    logic [BW-1:0]   bit_cnt;
    logic [PW-1:0]   ph_cnt;
    logic            phase;
    logic            ph_last, bit_last, start_load, start_refresh;

    always_comb begin
        ph_last       = (ph_cnt == PW'(DIV - 1));
        bit_last      = (bit_cnt == BW'(N - 1));
        start_load    = (state == IDLE) && en && data_valid;
        start_refresh = (state == IDLE) && en && !data_valid && mode && have_word;
        shreg_adv     = (MSB_FIRST != 0) ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};

        state_nx = state;
        case (state)
            IDLE:    if (start_load || start_refresh) state_nx = SHIFT;
            SHIFT:   if (ph_last && phase && bit_last) state_nx = LATCH;
            LATCH:   if (ph_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // data_ready is held low during reset even though the state already reads IDLE
        data_ready = reset_n && (state == IDLE) && en;
        busy       = (state != IDLE);
        sh_cp      = (state == SHIFT) && phase;
        st_cp      = (state == LATCH);
        ds         = (state == SHIFT) && ((MSB_FIRST != 0) ? shreg[N-1] : shreg[0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg      <= '0;
            hold       <= '0;
            have_word  <= 1'b0;
            bit_cnt    <= '0;
            ph_cnt     <= '0;
            phase      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    ph_cnt  <= '0;
                    phase   <= 1'b0;
                    bit_cnt <= '0;
                    if (start_load) begin
                        shreg     <= data_in;
                        hold      <= data_in;
                        have_word <= 1'b1;
                    end else if (start_refresh) begin
                        shreg <= hold;
                    end
                end
                SHIFT: begin
                    if (ph_last) begin
                        ph_cnt <= '0;
                        phase  <= ~phase;
                        // advance only after the high half of sh_cp has been served
                        if (phase) begin
                            shreg   <= shreg_adv;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        ph_cnt <= ph_cnt + PW'(1);
                    end
                end
                LATCH: begin
                    if (ph_last) begin
                        ph_cnt     <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hc595_chain_driver.sv
// Directed bench for hc595_chain_driver: default instance plus an 8-bit LSB-first, DIV=1 instance.
module tb_hc595_chain_driver;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        en, mode, data_valid;
    logic [15:0] data_in;
    logic        data_ready, sh_cp, st_cp, ds, busy, frame_done;
    logic        en_b, mode_b, valid_b;
    logic [7:0]  data_in_b;
    logic        ready_b, sh_b, st_b, ds_b, busy_b, fd_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    hc595_chain_driver dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .sh_cp(sh_cp), .st_cp(st_cp),
        .ds(ds), .busy(busy), .frame_done(frame_done)
    );

    hc595_chain_driver #(.CHAIN(1), .DIV(1), .MSB_FIRST(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en_b), .mode(mode_b), .data_in(data_in_b),
        .data_valid(valid_b), .data_ready(ready_b), .sh_cp(sh_b), .st_cp(st_b),
        .ds(ds_b), .busy(busy_b), .frame_done(fd_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Observes one frame of dut_a starting from the launch cycle (t=0); returns at frame_done.
    task automatic watch_a(input int v_at, input logic v_val, input logic [15:0] v_dat,
                           input int en_at, input logic en_val,
                           output logic [15:0] bits, output int nrise, output int st_first,
                           output int st_last, output int fd_at, output int rlo_first,
                           output int rlo_last, output int busy_n);
        logic prev_sh = 1'b0;
        bits = '0; nrise = 0; st_first = -1; st_last = -1; fd_at = -1;
        rlo_first = -1; rlo_last = -1; busy_n = 0;
        for (int t = 1; t <= 200; t++) begin
            tick();
            if (sh_cp && !prev_sh) begin
                bits = {bits[14:0], ds};
                nrise++;
            end
            prev_sh = sh_cp;
            if (st_cp) begin
                if (st_first < 0) st_first = t;
                st_last = t;
            end
            if (!data_ready) begin
                if (rlo_first < 0) rlo_first = t;
                rlo_last = t;
            end
            if (busy) busy_n++;
            if (t == 1) data_valid = 1'b0;
            if (t == v_at) begin
                data_valid = v_val;
                data_in    = v_dat;
            end
            if (t == en_at) en = en_val;
            if (frame_done) begin
                fd_at = t;
                break;
            end
        end
    endtask

    logic [15:0] bits;
    logic [7:0]  bits_b;
    int nrise, st_first, st_last, fd_at, rlo_first, rlo_last, busy_n, act;

    initial begin
        reset_n = 1'b0; en = 1'b1; mode = 1'b0; data_valid = 1'b0; data_in = '0;
        en_b = 1'b1; mode_b = 1'b0; valid_b = 1'b0; data_in_b = '0;

        // Reset state
        tick(); tick();
        chk("reset_outputs", {26'd0, sh_cp, st_cp, ds, busy, frame_done, data_ready}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("ready_after_reset", {31'd0, data_ready}, 32'd1);
        chk("idle_not_busy", {31'd0, busy}, 32'd0);

        // One-shot A5C3 with defaults
        tick();
        data_in = 16'hA5C3; data_valid = 1'b1;
        #1;
        chk("oneshot_ready_k", {31'd0, data_ready}, 32'd1);
        watch_a(0, 1'b0, '0, 0, 1'b1, bits, nrise, st_first, st_last, fd_at, rlo_first, rlo_last, busy_n);
        chk("oneshot_bits", bits, 32'hA5C3);
        chk("oneshot_nrise", nrise, 16);
        chk("oneshot_st_first", st_first, 65);
        chk("oneshot_st_last", st_last, 66);
        chk("oneshot_fd", fd_at, 67);
        chk("oneshot_rdy_lo_first", rlo_first, 1);
        chk("oneshot_rdy_lo_last", rlo_last, 66);
        chk("oneshot_busy_cycles", busy_n, 66);
        act = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (busy || sh_cp || st_cp || ds || frame_done) act++;
        end
        chk("oneshot_quiet_after", act, 0);

        // LSB-first, CHAIN=1, DIV=1: first bit sampled ends up in bits_b[7]
        data_in_b = 8'h01; valid_b = 1'b1;
        #1;
        chk("b_ready_k", {31'd0, ready_b}, 32'd1);
        begin
            logic prev = 1'b0;
            int   nr = 0, stn = 0, fdb = -1;
            bits_b = '0;
            for (int t = 1; t <= 60; t++) begin
                tick();
                if (t == 1) valid_b = 1'b0;
                if (sh_b && !prev) begin
                    bits_b = {bits_b[6:0], ds_b};
                    nr++;
                end
                prev = sh_b;
                if (st_b) stn++;
                if (fd_b) begin
                    fdb = t;
                    break;
                end
            end
            chk("b_bits", bits_b, 32'h80);
            chk("b_nrise", nr, 8);
            chk("b_st_cycles", stn, 1);
            chk("b_fd_period", fdb, 18);
        end

        // Back-to-back: valid held high with 0001 then 8000
        tick();
        data_in = 16'h0001; data_valid = 1'b1;
        watch_a(1, 1'b1, 16'h8000, 0, 1'b1, bits, nrise, st_first, st_last, fd_at, rlo_first, rlo_last, busy_n);
        chk("b2b_first_bits", bits, 32'h0001);
        chk("b2b_first_fd", fd_at, 67);
        chk("b2b_rdy_lo_first", rlo_first, 1);
        chk("b2b_rdy_lo_last", rlo_last, 66);
        chk("b2b_ready_at_fd", {31'd0, data_ready}, 32'd1);
        watch_a(0, 1'b0, '0, 0, 1'b1, bits, nrise, st_first, st_last, fd_at, rlo_first, rlo_last, busy_n);
        chk("b2b_second_bits", bits, 32'h8000);
        chk("b2b_second_st_first", st_first, 65);
        chk("b2b_second_fd", fd_at, 67);
        tick();

        // Auto-refresh of 1234, then FFFF presented mid-frame
        mode = 1'b1;
        data_in = 16'h1234; data_valid = 1'b1;
        watch_a(0, 1'b0, '0, 0, 1'b1, bits, nrise, st_first, st_last, fd_at, rlo_first, rlo_last, busy_n);
        chk("auto_first_bits", bits, 32'h1234);
        chk("auto_first_fd", fd_at, 67);
        watch_a(0, 1'b0, '0, 0, 1'b1, bits, nrise, st_first, st_last, fd_at, rlo_first, rlo_last, busy_n);
        chk("auto_refresh1_bits", bits, 32'h1234);
        chk("auto_refresh1_fd", fd_at, 67);
        watch_a(30, 1'b1, 16'hFFFF, 0, 1'b1, bits, nrise, st_first, st_last, fd_at, rlo_first, rlo_last, busy_n);
        chk("auto_refresh2_bits", bits, 32'h1234);
        chk("auto_refresh2_fd", fd_at, 67);
        watch_a(0, 1'b0, '0, 0, 1'b1, bits, nrise, st_first, st_last, fd_at, rlo_first, rlo_last, busy_n);
        chk("auto_new_word_bits", bits, 32'hFFFF);
        watch_a(0, 1'b0, '0, 0, 1'b1, bits, nrise, st_first, st_last, fd_at, rlo_first, rlo_last, busy_n);
        chk("auto_refresh_new_bits", bits, 32'hFFFF);
        chk("auto_refresh_new_fd", fd_at, 67);

        // Enable dropped at k+10 of a refresh frame
        watch_a(0, 1'b0, '0, 10, 1'b0, bits, nrise, st_first, st_last, fd_at, rlo_first, rlo_last, busy_n);
        chk("en_drop_bits", bits, 32'hFFFF);
        chk("en_drop_fd", fd_at, 67);
        chk("en_drop_ready_at_fd", {31'd0, data_ready}, 32'd0);
        act = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy || data_ready || sh_cp) act++;
        end
        chk("en_low_no_refresh", act, 0);
        en = 1'b1;
        #1;
        chk("en_raise_ready", {31'd0, data_ready}, 32'd1);
        watch_a(0, 1'b0, '0, 0, 1'b1, bits, nrise, st_first, st_last, fd_at, rlo_first, rlo_last, busy_n);
        chk("en_raise_refresh_bits", bits, 32'hFFFF);
        chk("en_raise_refresh_fd", fd_at, 67);

        // Reset asserted mid-frame during auto-refresh
        for (int i = 0; i < 20; i++) tick();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {26'd0, sh_cp, st_cp, ds, busy, frame_done, data_ready}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        #1;
        chk("post_reset_ready", {31'd0, data_ready}, 32'd1);
        act = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (busy || sh_cp || st_cp || frame_done) act++;
        end
        chk("post_reset_no_refresh", act, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/hc595_chain_driver.md
# hc595_chain_driver

Parametrised serial driver for a cascade of 74HC595 shift registers, generalising the current fixed 16-bit display serializer. It accepts a parallel word of `8*CHAIN` bits over a valid/ready handshake and shifts it out on `ds`/`sh_cp` at a programmable rate, then pulses `st_cp` to latch it. An auto-refresh mode continuously re-sends the last accepted word. It sits between the display generator (7-segment scan logic) and the board-level 595 chain.

## Interface
- `CHAIN`, default 2: number of cascaded 8-bit 595 devices; frame width N = 8*CHAIN bits; CHAIN >= 1.
- `DIV`, default 2: `clk` cycles per half period of `sh_cp` and width of the `st_cp` pulse; DIV >= 1.
- `MSB_FIRST`, default 1: 1 = `data_in[N-1]` shifted first; 0 = `data_in[0]` shifted first.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: enable; gates new frame starts only.
- `mode` in 1: 0 = one-shot (one frame per accepted word); 1 = auto-refresh.
- `data_in` in N: parallel word; sampled on the handshake.
- `data_valid` in 1: `data_in` valid.
- `data_ready` out 1: block can accept a word this cycle.
- `sh_cp` out 1: 595 shift clock.
- `st_cp` out 1: 595 storage/latch clock.
- `ds` out 1: 595 serial data.
- `busy` out 1: frame in progress (SHIFT or LATCH).
- `frame_done` out 1: single-cycle pulse at end of each frame.

## Operation
- States: IDLE, SHIFT, LATCH.
- Registers: shift register (N), hold register (N), `have_word` flag, bit counter (width clog2(N+1)), phase counter (width clog2(DIV), minimum 1), phase bit (low/high).
- IDLE: `data_ready` = `en` (combinational from state). On `data_valid & data_ready`, `data_in` loads into the shift and hold registers, `have_word` sets, and the state goes to SHIFT.
- Refresh: in IDLE with `en=1`, `mode=1`, `have_word=1` and `data_valid=0`, a frame starts from the hold register exactly as if a word had been accepted. A valid word in the same cycle takes priority.
- SHIFT: for each bit, `ds` presents the current bit and `sh_cp` is 0 for DIV cycles, then 1 for DIV cycles. The register then advances by one bit, toward the MSB or LSB side according to `MSB_FIRST`. After bit N-1's high phase, the state goes to LATCH.
- LATCH: `sh_cp`=0, `ds`=0, `st_cp`=1 for DIV cycles. The state then returns to IDLE and `frame_done` pulses in that first IDLE cycle.
- `ds`=0 and `sh_cp`=0 outside SHIFT. `st_cp`=0 outside LATCH.
- `en` deasserted mid-frame: the frame completes normally; no new frame starts (no accept, no refresh) while `en=0`.
- `mode` change mid-frame: takes effect at the next IDLE decision.
- `data_valid` while busy: `data_ready`=0; the word is not taken until IDLE. The source must hold it stable.
- Reset: all state is cleared immediately (async): IDLE, `have_word`=0, shift and hold registers = 0. Outputs: `sh_cp`=0, `st_cp`=0, `ds`=0, `busy`=0, `frame_done`=0, `data_ready`=0 while `reset_n`=0.

## Timing
- Let k be the accept (or refresh-launch) cycle.
- Bit i (0..N-1) `ds` valid from cycle k+1+2i·DIV.
- Bit i `sh_cp` rises at k+1+(2i+1)·DIV; `ds` is stable DIV cycles before and after each rising edge.
- `st_cp` is high for cycles k+1+2N·DIV through k+(2N+1)·DIV.
- `frame_done`=1 and `data_ready` (if `en`) = 1 at cycle F = k+1+(2N+1)·DIV. The next accept can occur in that same cycle, giving a back-to-back period of (2N+1)·DIV+1 cycles.
- `busy`=1 from k+1 through F-1.
- Defaults (CHAIN=2, DIV=2): N=16, frame period 67 cycles.

## Test plan
- Reset: assert `reset_n`=0 mid-frame → all outputs 0 asynchronously. After release with `en=1`, `data_ready`=1. With `mode=1`, no refresh occurs because `have_word` was cleared.
- One-shot, defaults: accept 16'hA5C3 at k → `ds` sampled at the 16 `sh_cp` rises = 1010_0101_1100_0011. `st_cp` is high for exactly 2 cycles at k+65..k+66. `frame_done` pulses at k+67. No further activity follows.
- `MSB_FIRST=0`, CHAIN=1, DIV=1: accept 8'h01 → first sampled bit 1, the remaining seven 0. Frame period 18 cycles.
- Back-to-back: `data_valid` held high with words 16'h0001 and 16'h8000 → second accept at k+67, second frame identical in timing; `data_ready` low for k+1..k+66.
- Auto-refresh: `mode=1`, accept 16'h1234, then `data_valid`=0 → frames repeat every 67 cycles with identical bits. Presenting 16'hFFFF mid-frame → it is accepted at the frame end, and subsequent refresh frames carry 16'hFFFF.
- Enable gating: drop `en` at cycle k+10 → the frame completes with `frame_done` at k+67, then `data_ready`=0 and no refresh. Raise `en` again → a refresh launches the same cycle.
